// File: rtl/dt_walk_engine.sv
// rtl/dt_walk_engine.sv - table-driven decision-tree walk engine, one tree level per clock
module dt_walk_engine #(
    parameter int N_FEAT    = 12,
    parameter int CLASS_W   = 3,
    parameter int N_NODES   = 64,
    parameter int MAX_DEPTH = 16,
    localparam int ADDR_W   = $clog2(N_NODES),
    localparam int FIDX_W   = $clog2(N_FEAT),
    localparam int DEPTH_W  = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic               cfg_leaf,
    input  logic [FIDX_W-1:0]  cfg_feat,
    input  logic [ADDR_W-1:0]  cfg_lo,
    input  logic [ADDR_W-1:0]  cfg_hi,
    input  logic [CLASS_W-1:0] cfg_class,
    output logic               cfg_drop,
    input  logic               in_valid,
    input  logic [N_FEAT-1:0]  in_feat,
    output logic               in_ready,
    output logic               out_valid,
    output logic [CLASS_W-1:0] out_class,
    output logic               out_err,
    output logic [DEPTH_W-1:0] out_depth,
    input  logic               out_ready
);

    // Range limits widened by one bit so the comparisons never wrap.
    localparam logic [ADDR_W:0]    NODES_LIM = N_NODES[ADDR_W:0];
    localparam logic [FIDX_W:0]    FEAT_LIM  = N_FEAT[FIDX_W:0];
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = MAX_DEPTH[DEPTH_W-1:0];

    // FIN is the commit cycle between the terminal node and the visible result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, next_state;

    logic               tbl_leaf  [N_NODES];
    logic [FIDX_W-1:0]  tbl_feat  [N_NODES];
    logic [ADDR_W-1:0]  tbl_lo    [N_NODES];
    logic [ADDR_W-1:0]  tbl_hi    [N_NODES];
    logic [CLASS_W-1:0] tbl_class [N_NODES];

    logic [N_FEAT-1:0]  vec;
    logic [ADDR_W-1:0]  cur;
    logic [DEPTH_W-1:0] depth;

    logic               cur_leaf;
    logic [FIDX_W-1:0]  cur_feat;
    logic [CLASS_W-1:0] cur_class;
    logic               feat_ok;
    logic               feat_bit;
    logic [ADDR_W-1:0]  next_node;
    logic               next_ok;
    logic               depth_hit;
    logic               walk_end;

    // Combinational node read and branch decision for the current node.
    always_comb begin
        cur_leaf  = tbl_leaf[cur];
        cur_feat  = tbl_feat[cur];
        cur_class = tbl_class[cur];
        feat_ok   = ({1'b0, cur_feat} < FEAT_LIM);
        feat_bit  = feat_ok ? vec[cur_feat] : 1'b0;
        next_node = feat_bit ? tbl_hi[cur] : tbl_lo[cur];
        next_ok   = ({1'b0, next_node} < NODES_LIM);
        depth_hit = (depth == DEPTH_MAX);
        walk_end  = cur_leaf | depth_hit | ~feat_ok | ~next_ok;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs; a config write in IDLE blocks acceptance.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~cfg_we;
                if (in_valid && !cfg_we) begin
                    next_state = WALK;
                end
            end
            WALK: begin
                if (walk_end) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Node table: reset to all-leaf class 0; writes land only while IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NODES; i++) begin
                tbl_leaf[i]  <= 1'b1;
                tbl_feat[i]  <= '0;
                tbl_lo[i]    <= '0;
                tbl_hi[i]    <= '0;
                tbl_class[i] <= '0;
            end
        end else if (cfg_we && state == IDLE && ({1'b0, cfg_addr} < NODES_LIM)) begin
            tbl_leaf[cfg_addr]  <= cfg_leaf;
            tbl_feat[cfg_addr]  <= cfg_feat;
            tbl_lo[cfg_addr]    <= cfg_lo;
            tbl_hi[cfg_addr]    <= cfg_hi;
            tbl_class[cfg_addr] <= cfg_class;
        end
    end

    // Walk datapath: latch the sample, step one level per cycle, capture the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec       <= '0;
            cur       <= '0;
            depth     <= '0;
            out_class <= '0;
            out_err   <= 1'b0;
            out_depth <= '0;
            cfg_drop  <= 1'b0;
        end else begin
            cfg_drop <= cfg_we & (state != IDLE);
            case (state)
                IDLE: begin
                    if (in_valid && !cfg_we) begin
                        vec   <= in_feat;
                        cur   <= '0;
                        depth <= '0;
                    end
                end
                WALK: begin
                    if (cur_leaf) begin
                        out_class <= cur_class;
                        out_err   <= 1'b0;
                        out_depth <= depth;
                    end else if (depth_hit) begin
                        out_class <= '0;
                        out_err   <= 1'b1;
                        out_depth <= DEPTH_MAX;
                    end else if (!feat_ok || !next_ok) begin
                        out_class <= '0;
                        out_err   <= 1'b1;
                        out_depth <= depth;
                    end else begin
                        cur   <= next_node;
                        depth <= depth + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
